rx_decimator: RTL and testbench

//  Receive front end between ADC pins rx_a_a/rx_a_b and rx_buffer. Registers two 12-bit ADC streams (I, Q) on rx_clk.

---
 rtl/rx_decimator_pkg.sv | 55 +++++
 rtl/rx_decimator_if.sv | 33 +++
 rtl/rx_decimator_cic2_dec.sv | 107 ++++++++++
 rtl/rx_decimator.sv | 115 +++++++++++
 tb/tb_rx_decimator.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/rx_decimator_pkg.sv
// rx_decimator_pkg
// Shared constants, the CONFIG register layout and saturation helpers for
// the receive decimator (rx_decimator top and its per-channel CIC slice).
//   RX_CONFIG_ADDR : serial address of the CONFIG register
//   CFG_*          : bit positions of the CONFIG fields
//   ADC_W/OUT_W/RATE_W/ACC_W : datapath widths
//   DC_W/DC_SHIFT  : DC tracker width and time constant (RX_DC_OFFSET_EN)
package rx_decimator_pkg;

    localparam int ADC_W    = 12;
    localparam int OUT_W    = 16;
    localparam int RATE_W   = 8;
    localparam int ACC_W    = ADC_W + 2 * RATE_W;
    localparam int SHIFT_W  = 4;
    localparam int DC_W     = 22;
    localparam int DC_SHIFT = 10;

    localparam logic [6:0] RX_CONFIG_ADDR = 7'd8;

    localparam int CFG_RATE_LSB  = 0;
    localparam int CFG_SHIFT_LSB = 8;
    localparam int CFG_EN_BIT    = 31;

    // Number of dumps discarded after a restart while the combs fill up.
    localparam logic [1:0] WARMUP_DUMPS = 2'd2;

    typedef struct packed {
        logic                enable;
        logic [SHIFT_W-1:0]  shift;
        logic [RATE_W-1:0]   decimRateM1;
    } cfg_t;

    // Clamp an accumulator-width value into the signed output range.
    function automatic logic signed [OUT_W-1:0] satOut(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-OUT_W:0] upper;
        upper = v[ACC_W-1:OUT_W-1];
        if (upper == '0 || upper == '1)
            satOut = v[OUT_W-1:0];
        else if (v[ACC_W-1])
            satOut = {1'b1, {(OUT_W-1){1'b0}}};
        else
            satOut = {1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    // Clamp a one-bit-wider difference back into the ADC sample range.
    function automatic logic signed [ADC_W-1:0] satAdc(input logic [ADC_W:0] v);
        if (v[ADC_W] == v[ADC_W-1])
            satAdc = v[ADC_W-1:0];
        else if (v[ADC_W])
            satAdc = {1'b1, {(ADC_W-1){1'b0}}};
        else
            satAdc = {1'b0, {(ADC_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/rx_decimator_if.sv
// rx_decimator_if
// Bundles the register bus, ADC pins and decimated outputs of rx_decimator.
//   reset_regs, serial_strobe, serial_addr[6:0], serial_data[31:0] : config bus
//   rx_a_a, rx_a_b [11:0]  : ADC I/Q samples
//   ch_0, ch_1 [15:0]      : decimated I/Q
//   rxstrobe               : one-cycle valid for ch_0/ch_1
//   debug_bus [15:0]       : {rxstrobe, enable, warmup, 4'b0, count}
// master modport = driver of pins/bus (host side), slave modport = decimator.
interface rx_decimator_if;
    import rx_decimator_pkg::*;

    logic                    reset_regs;
    logic                    serial_strobe;
    logic [6:0]              serial_addr;
    logic [31:0]             serial_data;
    logic signed [ADC_W-1:0] rx_a_a;
    logic signed [ADC_W-1:0] rx_a_b;
    logic signed [OUT_W-1:0] ch_0;
    logic signed [OUT_W-1:0] ch_1;
    logic                    rxstrobe;
    logic [15:0]             debug_bus;

    modport master (
        output reset_regs, serial_strobe, serial_addr, serial_data, rx_a_a, rx_a_b,
        input  ch_0, ch_1, rxstrobe, debug_bus
    );

    modport slave (
        input  reset_regs, serial_strobe, serial_addr, serial_data, rx_a_a, rx_a_b,
        output ch_0, ch_1, rxstrobe, debug_bus
    );

endinterface

// File: rtl/rx_decimator_cic2_dec.sv
// rx_decimator_cic2_dec
// One channel of the decimator: input register, optional DC tracker,
// two integrators, two combs evaluated on dump, then shift and saturate.
//   rx_clk, reset : clock and asynchronous active-high reset
//   i_restart     : clears all channel state (config write / reset_regs)
//   i_enable      : datapath advances only while high
//   i_dump        : decimation instant, latches the comb result
//   i_shift       : arithmetic right shift applied before saturation
//   i_adc         : raw ADC sample
//   o_sample      : saturated output of the most recent dump
// Optional feature macro: RX_DC_OFFSET_EN (DC removal ahead of the CIC).
module rx_decimator_cic2_dec
    import rx_decimator_pkg::*;
(
    input  logic                      rx_clk,
    input  logic                      reset,
    input  logic                      i_restart,
    input  logic                      i_enable,
    input  logic                      i_dump,
    input  logic [SHIFT_W-1:0]        i_shift,
    input  logic signed [ADC_W-1:0]   i_adc,
    output logic signed [OUT_W-1:0]   o_sample
);

    logic signed [ADC_W-1:0] r_x;
    logic signed [ACC_W-1:0] r_int1;
    logic signed [ACC_W-1:0] r_int2;
    logic signed [ACC_W-1:0] r_d1;
    logic signed [ACC_W-1:0] r_d2;
    logic signed [ACC_W-1:0] r_c2;
    logic signed [ADC_W-1:0] w_src;
    logic signed [ACC_W-1:0] w_cicIn;
    logic signed [ACC_W-1:0] w_c1;
    logic signed [ACC_W-1:0] w_c2;
    logic signed [ACC_W-1:0] w_shifted;

`ifdef RX_DC_OFFSET_EN
    logic signed [DC_W-1:0]  r_dc;
    logic signed [ADC_W-1:0] r_xClean;
    logic signed [DC_W-1:0]  w_dcEst;
    logic [ADC_W:0]          w_diff;

    // The tracker is a leaky accumulator whose steady state is 2^DC_SHIFT
    // times the input mean, so dc >>> DC_SHIFT is the offset estimate.
    assign w_dcEst = r_dc >>> DC_SHIFT;
    assign w_diff  = {r_x[ADC_W-1], r_x} - {w_dcEst[ADC_W-1], w_dcEst[ADC_W-1:0]};

    // DC tracker and the corrected sample; the corrected sample is
    // registered, which costs one extra cycle of latency.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            r_dc     <= '0;
            r_xClean <= '0;
        end else if (i_restart) begin
            r_dc     <= '0;
            r_xClean <= '0;
        end else if (i_enable) begin
            r_dc     <= r_dc + {{(DC_W-ADC_W){r_x[ADC_W-1]}}, r_x} - w_dcEst;
            r_xClean <= satAdc(w_diff);
        end
    end

    assign w_src = r_xClean;
`else
    assign w_src = r_x;
`endif

    assign w_cicIn = {{(ACC_W-ADC_W){w_src[ADC_W-1]}}, w_src};

    // Comb stage is combinational off int2 and only committed on dump.
    // All arithmetic is modulo 2^ACC_W; the final comb output is exact
    // because ACC_W covers the full R^2 gain.
    assign w_c1 = r_int2 - r_d1;
    assign w_c2 = w_c1 - r_d2;

    // Input register, integrators and comb delay lines.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            r_x    <= '0;
            r_int1 <= '0;
            r_int2 <= '0;
            r_d1   <= '0;
            r_d2   <= '0;
            r_c2   <= '0;
        end else if (i_restart) begin
            r_x    <= '0;
            r_int1 <= '0;
            r_int2 <= '0;
            r_d1   <= '0;
            r_d2   <= '0;
            r_c2   <= '0;
        end else if (i_enable) begin
            r_x    <= i_adc;
            r_int1 <= r_int1 + w_cicIn;
            r_int2 <= r_int2 + r_int1;
            if (i_dump) begin
                r_d1 <= r_int2;
                r_d2 <= w_c1;
                r_c2 <= w_c2;
            end
        end
    end

    assign w_shifted = r_c2 >>> i_shift;
    assign o_sample  = satOut(w_shifted);

endmodule

// File: rtl/rx_decimator.sv
// rx_decimator
// Receive front end: registers the I/Q ADC streams, decimates each by
// R = decim_rate_m1 + 1 with a 2nd-order CIC, scales, saturates to 16 bits
// and presents ch_0/ch_1 with a one-cycle rxstrobe.
//   rx_clk : sample clock, all logic on the rising edge
//   reset  : asynchronous active-high, clears all state
//   bus    : rx_decimator_if.slave (register bus, ADC pins, outputs)
// CONFIG register at REG_BASE: [7:0] decim_rate_m1, [11:8] shift, [31] enable.
// Optional feature macro: RX_DC_OFFSET_EN (enables DC removal in each channel).
module rx_decimator
    import rx_decimator_pkg::*;
#(
    parameter logic [6:0] REG_BASE = RX_CONFIG_ADDR
) (
    input  logic             rx_clk,
    input  logic             reset,
    rx_decimator_if.slave    bus
);

    cfg_t                    r_cfg;
    logic [RATE_W-1:0]       r_count;
    logic [1:0]              r_warmup;
    logic                    r_pending;
    logic                    r_rxstrobe;
    logic signed [OUT_W-1:0] r_ch0;
    logic signed [OUT_W-1:0] r_ch1;
    logic signed [OUT_W-1:0] w_ch0;
    logic signed [OUT_W-1:0] w_ch1;
    logic                    w_cfgWrite;
    logic                    w_restart;
    logic                    w_dump;
    logic [RATE_W-1:0]       w_reloadM1;
    logic                    w_unusedData;

    assign w_cfgWrite   = bus.serial_strobe && (bus.serial_addr == REG_BASE);
    assign w_restart    = bus.reset_regs || w_cfgWrite;
    assign w_dump       = r_cfg.enable && (r_count == '0);
    assign w_reloadM1   = bus.reset_regs ? '0 : bus.serial_data[CFG_RATE_LSB +: RATE_W];
    assign w_unusedData = ^bus.serial_data[CFG_EN_BIT-1:CFG_SHIFT_LSB+SHIFT_W];

    // CONFIG register; reset_regs outranks a simultaneous bus write.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            r_cfg <= '0;
        end else if (bus.reset_regs) begin
            r_cfg <= '0;
        end else if (w_cfgWrite) begin
            r_cfg.enable      <= bus.serial_data[CFG_EN_BIT];
            r_cfg.shift       <= bus.serial_data[CFG_SHIFT_LSB +: SHIFT_W];
            r_cfg.decimRateM1 <= bus.serial_data[CFG_RATE_LSB +: RATE_W];
        end
    end

    // Decimation counter, warmup and strobe generation. A restart wins over
    // a coincident dump or pending strobe so no value from the old rate can
    // leak out. The dump is flagged in r_pending and the output is taken one
    // cycle later, once the comb result has been registered in the channels.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_warmup   <= '0;
            r_pending  <= 1'b0;
            r_rxstrobe <= 1'b0;
            r_ch0      <= '0;
            r_ch1      <= '0;
        end else begin
            r_rxstrobe <= 1'b0;
            if (w_restart) begin
                r_count   <= w_reloadM1;
                r_warmup  <= WARMUP_DUMPS;
                r_pending <= 1'b0;
            end else if (r_cfg.enable) begin
                r_count   <= w_dump ? r_cfg.decimRateM1 : r_count - RATE_W'(1);
                r_pending <= w_dump;
                if (r_pending) begin
                    if (r_warmup == '0) begin
                        r_ch0      <= w_ch0;
                        r_ch1      <= w_ch1;
                        r_rxstrobe <= 1'b1;
                    end else begin
                        r_warmup <= r_warmup - 2'd1;
                    end
                end
            end
        end
    end

    rx_decimator_cic2_dec u_cicI (
        .rx_clk    (rx_clk),
        .reset     (reset),
        .i_restart (w_restart),
        .i_enable  (r_cfg.enable),
        .i_dump    (w_dump),
        .i_shift   (r_cfg.shift),
        .i_adc     (bus.rx_a_a),
        .o_sample  (w_ch0)
    );

    rx_decimator_cic2_dec u_cicQ (
        .rx_clk    (rx_clk),
        .reset     (reset),
        .i_restart (w_restart),
        .i_enable  (r_cfg.enable),
        .i_dump    (w_dump),
        .i_shift   (r_cfg.shift),
        .i_adc     (bus.rx_a_b),
        .o_sample  (w_ch1)
    );

    assign bus.ch_0      = r_ch0;
    assign bus.ch_1      = r_ch1;
    assign bus.rxstrobe  = r_rxstrobe;
    assign bus.debug_bus = {r_rxstrobe, r_cfg.enable, r_warmup, 4'b0000, r_count};

endmodule

// File: tb/tb_rx_decimator.sv
// tb_rx_decimator
// Self-checking bench for rx_decimator. Each run writes CONFIG, drives the
// ADC pins and predicts every cycle's rxstrobe/ch_0/ch_1 from the CIC
// definition: a dump every R cycles after restart, the first two dumps
// discarded, output = second difference of the double running sum of the
// input taken R apart, shifted and clamped to 16 bits.
// Macro RX_DC_OFFSET_EN selects the DC removal scenario instead.
module tb_rx_decimator;

    logic rx_clk = 1'b0;
    logic reset  = 1'b1;

    rx_decimator_if bus ();

    rx_decimator dut (
        .rx_clk (rx_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 rx_clk = ~rx_clk;

    int     vectors     = 0;
    int     miscompares = 0;
    longint expCh0      = 0;
    longint expCh1      = 0;

    // Single point of comparison for the whole bench.
    task automatic checkOutput(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Pin pattern: 0 = constant, 1 = random, otherwise a wrapping ramp.
    function automatic int pinValue(input int mode, input int val, input int n);
        int t;
        if (mode == 0) return val;
        if (mode == 1) return int'($urandom_range(0, 4095)) - 2048;
        t = ((val + 13 * n) % 4096 + 4096) % 4096;
        return (t >= 2048) ? t - 4096 : t;
    endfunction

    // Value of the second integrator after n cycles: each sample q[m]
    // has been summed into it (n-1-m) times.
    function automatic longint int2At(input int q[$], input int n);
        longint s;
        s = 0;
        for (int m = 0; m <= n - 2; m++) s += longint'(n - 1 - m) * longint'(q[m]);
        return s;
    endfunction

    function automatic longint cicOut(input int q[$], input int k, input int r, input int sh);
        longint c2;
        c2 = int2At(q, k * r - 1) - 2 * int2At(q, (k - 1) * r - 1) + int2At(q, (k - 2) * r - 1);
        c2 = c2 >>> sh;
        if (c2 > 32767) c2 = 32767;
        else if (c2 < -32768) c2 = -32768;
        return c2;
    endfunction

    task automatic writeConfig(input logic [31:0] data);
        bus.serial_addr   = 7'd8;
        bus.serial_data   = data;
        bus.serial_strobe = 1'b1;
        @(posedge rx_clk);
        #1;
        bus.serial_strobe = 1'b0;
    endtask

    // Write CONFIG, then drive nCyc cycles of pins and check every cycle.
    task automatic applyStimulus(input int m1, input int sh, input bit en, input int nCyc,
                                 input int modeA, input int valA, input int modeB, input int valB);
        int  r;
        int  k;
        int  pa;
        int  pb;
        int  qa[$];
        int  qb[$];
        bit  expStb;
        logic [31:0] cfgWord;
        r = m1 + 1;
        cfgWord = {en, 19'd0, sh[3:0], m1[7:0]};
        writeConfig(cfgWord);
        checkOutput("wr_strobe", bus.rxstrobe, 0);
        checkOutput("wr_ch0", bus.ch_0, expCh0);
        checkOutput("wr_ch1", bus.ch_1, expCh1);
        checkOutput("wr_debug", bus.debug_bus, (longint'(en) << 14) + 'h2000 + m1);
        qa.delete();
        qb.delete();
        qa.push_back(0);
        qb.push_back(0);
        for (int n = 1; n <= nCyc; n++) begin
            pa = pinValue(modeA, valA, n);
            pb = pinValue(modeB, valB, n);
            bus.rx_a_a = pa[11:0];
            bus.rx_a_b = pb[11:0];
            @(posedge rx_clk);
            #1;
            if (en) begin
                qa.push_back(pa);
                qb.push_back(pb);
            end
            expStb = en && ((n - 1) >= 3 * r) && (((n - 1) % r) == 0);
            if (expStb) begin
                k = (n - 1) / r;
                expCh0 = cicOut(qa, k, r, sh);
                expCh1 = cicOut(qb, k, r, sh);
            end
            checkOutput("rxstrobe", bus.rxstrobe, expStb);
            checkOutput("ch_0", bus.ch_0, expCh0);
            checkOutput("ch_1", bus.ch_1, expCh1);
        end
    endtask

    initial begin
        bus.reset_regs    = 1'b0;
        bus.serial_strobe = 1'b0;
        bus.serial_addr   = '0;
        bus.serial_data   = '0;
        bus.rx_a_a        = '0;
        bus.rx_a_b        = '0;
        repeat (3) @(posedge rx_clk);
        #1;
        checkOutput("rst_ch0", bus.ch_0, 0);
        checkOutput("rst_ch1", bus.ch_1, 0);
        checkOutput("rst_strobe", bus.rxstrobe, 0);
        checkOutput("rst_debug", bus.debug_bus, 0);
        reset = 1'b0;
        @(posedge rx_clk);
        #1;

`ifdef RX_DC_OFFSET_EN
        writeConfig(32'h8000_0403);
        bus.rx_a_a = 12'd500;
        bus.rx_a_b = -12'sd700;
        repeat (20000) @(posedge rx_clk);
        #1;
        checkOutput("dc_ch0_small", (bus.ch_0 < 16 && bus.ch_0 > -16) ? 1 : 0, 1);
        checkOutput("dc_ch1_small", (bus.ch_1 < 16 && bus.ch_1 > -16) ? 1 : 0, 1);
`else
        // R=4 constant 100: steady output is 100 * R^2.
        applyStimulus(3, 0, 1, 40, 0, 100, 1, 0);
        checkOutput("gain_r4", bus.ch_0, 1600);
        applyStimulus(3, 4, 1, 30, 0, 100, 0, -5);
        checkOutput("gain_r4_shift4", bus.ch_0, 100);

        // Full-scale inputs at R=256 clamp at both ends.
        applyStimulus(255, 0, 1, 1100, 0, 2047, 0, -2048);
        checkOutput("sat_pos", bus.ch_0, 32767);
        checkOutput("sat_neg", bus.ch_1, -32768);

        // R=1: continuous strobe, output is the input four cycles late.
        applyStimulus(0, 0, 1, 50, 2, 100, 1, 0);

        // Rewrite lands on a dump edge, then on a pending-strobe edge.
        applyStimulus(3, 2, 1, 23, 1, 0, 1, 0);
        applyStimulus(7, 2, 1, 70, 1, 0, 2, 7);
        applyStimulus(3, 1, 1, 24, 1, 0, 1, 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(int'($urandom_range(0, 12)), int'($urandom_range(0, 8)), 1,
                          int'($urandom_range(10, 90)),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 4095)) - 2048,
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 4095)) - 2048);
        end

        // Disabled: frozen at restart values, no strobes.
        applyStimulus(5, 0, 0, 20, 1, 0, 1, 0);
        checkOutput("dis_debug", bus.debug_bus, 'h2005);

        // reset_regs returns CONFIG to defaults and restarts.
        applyStimulus(2, 0, 1, 15, 1, 0, 1, 0);
        bus.reset_regs = 1'b1;
        @(posedge rx_clk);
        #1;
        bus.reset_regs = 1'b0;
        checkOutput("rr_debug", bus.debug_bus, 'h2000);
        checkOutput("rr_ch0", bus.ch_0, expCh0);
        repeat (10) @(posedge rx_clk);
        #1;
        checkOutput("rr_strobe", bus.rxstrobe, 0);

        // Asynchronous reset between dumps clears outputs immediately.
        applyStimulus(3, 0, 1, 22, 1, 0, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_ch0", bus.ch_0, 0);
        checkOutput("arst_ch1", bus.ch_1, 0);
        checkOutput("arst_strobe", bus.rxstrobe, 0);
        checkOutput("arst_debug", bus.debug_bus, 0);
        @(posedge rx_clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge rx_clk);
        #1;
        checkOutput("post_rst_ch0", bus.ch_0, 0);
        checkOutput("post_rst_strobe", bus.rxstrobe, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
